// File: rtl/up_down_monitor.sv
// -----------------------------------------------------------------------------
// up_down_monitor
//
// Watches the value of a 3-bit up/down counter and works out which direction
// it is counting. Each accepted sample is compared with the previous accepted
// sample. The difference, taken mod 8, is classified as one of:
//   UP (+1), DOWN (-1, i.e. 7), HOLD (0) or ERR (anything else).
// A run of LOCK_N consecutive steps in the same direction locks the monitor
// onto that direction. While locked, a single step in the opposite direction
// flips the lock and is reported as a reversal. An illegal step drops the
// lock and is counted.
//
// Parameters
//   LOCK_N    : consecutive same-direction steps needed to lock (1..7)
//   ERR_W     : width of the saturating error counter
//
// Ports
//   clk       : clock, all state changes on the rising edge
//   clr       : asynchronous active-low reset
//   q_in      : observed counter value
//   sample_en : q_in is only looked at when this is high
//   m_out     : inferred counter mode, 0 = up, 1 = down
//   locked    : high while a direction is established
//   wrap      : one-cycle pulse on a 7->0 up step or a 0->7 down step
//   rev       : one-cycle pulse when a locked direction reverses
//   step_err  : one-cycle pulse on an illegal transition
//   err_cnt   : saturating count of illegal transitions
//
// All outputs are registered, so they describe the sample taken on the
// previous rising edge.
// -----------------------------------------------------------------------------
module up_down_monitor #(
  parameter int LOCK_N = 2,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [2:0]       q_in,
  input  logic             sample_en,
  output logic             m_out,
  output logic             locked,
  output logic             wrap,
  output logic             rev,
  output logic             step_err,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ACQ,
    ST_LOCK_UP,
    ST_LOCK_DOWN
  } state_t;

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_UP,
    STEP_DOWN,
    STEP_ERR
  } step_t;

  localparam logic [2:0]       LOCK_N_L = 3'(LOCK_N);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           state_q,    state_d;
  logic [2:0]       prev_q,     prev_d;
  logic [2:0]       run_q,      run_d;
  logic             cand_q,     cand_d;
  logic             m_out_q,    m_out_d;
  logic             locked_q,   locked_d;
  logic             wrap_q,     wrap_d;
  logic             rev_q,      rev_d;
  logic             step_err_q, step_err_d;
  logic [ERR_W-1:0] err_cnt_q,  err_cnt_d;

  logic [2:0] delta;
  step_t      step;
  logic       step_down;
  logic [2:0] run_next;

  // The 3-bit subtraction wraps naturally, which is exactly delta mod 8.
  assign delta     = q_in - prev_q;
  assign step_down = (step == STEP_DOWN);

  always_comb begin
    step = STEP_ERR;
    unique case (delta)
      3'd0:    step = STEP_HOLD;
      3'd1:    step = STEP_UP;
      3'd7:    step = STEP_DOWN;
      default: step = STEP_ERR;
    endcase
  end

  // Run length during acquisition: a step that agrees with the candidate
  // direction extends the run, any other step starts a fresh run of one in
  // the new direction. From run=0 both cases give 1, so the candidate left
  // over from earlier history never matters once the run has been cleared.
  always_comb begin
    run_next = 3'd1;
    if (step_down == cand_q) begin
      run_next = run_q + 3'd1;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d    = state_q;
    prev_d     = prev_q;
    run_d      = run_q;
    cand_d     = cand_q;
    m_out_d    = m_out_q;
    wrap_d     = 1'b0;
    rev_d      = 1'b0;
    step_err_d = 1'b0;
    err_cnt_d  = err_cnt_q;

    if (sample_en) begin
      prev_d = q_in;

      // Without a previous sample there is no step, so no wrap either.
      if (state_q != ST_EMPTY) begin
        wrap_d = ((step == STEP_UP) && (q_in == 3'd0)) ||
                 ((step == STEP_DOWN) && (q_in == 3'd7));
      end

      unique case (state_q)
        ST_EMPTY: begin
          state_d = ST_ACQ;
          run_d   = 3'd0;
        end

        ST_ACQ: begin
          unique case (step)
            STEP_UP, STEP_DOWN: begin
              cand_d = step_down;
              run_d  = run_next;
              // The run is cleared on lock so a later loss of lock always
              // starts acquisition from scratch.
              if (run_next == LOCK_N_L) begin
                state_d = step_down ? ST_LOCK_DOWN : ST_LOCK_UP;
                m_out_d = step_down;
                run_d   = 3'd0;
              end
            end
            STEP_ERR: begin
              run_d      = 3'd0;
              step_err_d = 1'b1;
            end
            default: begin
            end
          endcase
        end

        ST_LOCK_UP: begin
          unique case (step)
            STEP_DOWN: begin
              state_d = ST_LOCK_DOWN;
              m_out_d = 1'b1;
              rev_d   = 1'b1;
            end
            STEP_ERR: begin
              state_d    = ST_ACQ;
              run_d      = 3'd0;
              step_err_d = 1'b1;
            end
            default: begin
            end
          endcase
        end

        ST_LOCK_DOWN: begin
          unique case (step)
            STEP_UP: begin
              state_d = ST_LOCK_UP;
              m_out_d = 1'b0;
              rev_d   = 1'b1;
            end
            STEP_ERR: begin
              state_d    = ST_ACQ;
              run_d      = 3'd0;
              step_err_d = 1'b1;
            end
            default: begin
            end
          endcase
        end

        default: begin
          state_d = ST_EMPTY;
        end
      endcase

      // The error counter sticks at all-ones rather than wrapping.
      if (step_err_d && (err_cnt_q != ERR_MAX)) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end

    locked_d = (state_d == ST_LOCK_UP) || (state_d == ST_LOCK_DOWN);
  end

  // State and output registers, cleared asynchronously by clr.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q    <= ST_EMPTY;
      prev_q     <= 3'd0;
      run_q      <= 3'd0;
      cand_q     <= 1'b0;
      m_out_q    <= 1'b0;
      locked_q   <= 1'b0;
      wrap_q     <= 1'b0;
      rev_q      <= 1'b0;
      step_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      run_q      <= run_d;
      cand_q     <= cand_d;
      m_out_q    <= m_out_d;
      locked_q   <= locked_d;
      wrap_q     <= wrap_d;
      rev_q      <= rev_d;
      step_err_q <= step_err_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign m_out    = m_out_q;
  assign locked   = locked_q;
  assign wrap     = wrap_q;
  assign rev      = rev_q;
  assign step_err = step_err_q;
  assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_up_down_monitor.sv
// -----------------------------------------------------------------------------
// tb_up_down_monitor
//
// Drives two monitors from the same stimulus: one with the default
// parameters and one with LOCK_N=1, ERR_W=2 so that single-step locking and
// counter saturation are exercised. Every output of both is compared each
// cycle against a behavioural model, the default instance is also compared
// against a hand-written table of scenarios, and a few multi-cycle sequences
// cover asynchronous reset and error saturation.
// -----------------------------------------------------------------------------
module tb_up_down_monitor;

  logic       clk = 1'b0;
  logic       clr;
  logic [2:0] q_in;
  logic       sample_en;

  logic       m_out_a, locked_a, wrap_a, rev_a, step_err_a;
  logic [7:0] err_cnt_a;
  logic       m_out_b, locked_b, wrap_b, rev_b, step_err_b;
  logic [1:0] err_cnt_b;

  int checks = 0;
  int errors = 0;

  up_down_monitor #(.LOCK_N(2), .ERR_W(8)) dut_a (
    .clk(clk), .clr(clr), .q_in(q_in), .sample_en(sample_en),
    .m_out(m_out_a), .locked(locked_a), .wrap(wrap_a), .rev(rev_a),
    .step_err(step_err_a), .err_cnt(err_cnt_a)
  );

  up_down_monitor #(.LOCK_N(1), .ERR_W(2)) dut_b (
    .clk(clk), .clr(clr), .q_in(q_in), .sample_en(sample_en),
    .m_out(m_out_b), .locked(locked_b), .wrap(wrap_b), .rev(rev_b),
    .step_err(step_err_b), .err_cnt(err_cnt_b)
  );

  always #5 clk = ~clk;

  // Behavioural model: lock is -1 when not locked, else 0 = up, 1 = down.
  typedef struct {
    int have_prev;
    int prev;
    int run;
    int cand;
    int lock;
    int mout;
    int errc;
    int wrap;
    int rev;
    int serr;
  } model_t;

  model_t mdl [2];

  function automatic int lockNOf(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic int errMaxOf(input int i);
    return (i == 0) ? 255 : 3;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mdl[i].have_prev = 0; mdl[i].prev = 0; mdl[i].run = 0; mdl[i].cand = 0;
      mdl[i].lock = -1; mdl[i].mout = 0; mdl[i].errc = 0;
      mdl[i].wrap = 0; mdl[i].rev = 0; mdl[i].serr = 0;
    end
  endtask

  task automatic modelStep(input int i, input bit en, input int q);
    int d;
    int dir;
    mdl[i].wrap = 0; mdl[i].rev = 0; mdl[i].serr = 0;
    if (!en) return;
    if (mdl[i].have_prev == 0) begin
      mdl[i].have_prev = 1;
      mdl[i].prev = q;
      mdl[i].run = 0;
      return;
    end
    d = (q - mdl[i].prev + 8) % 8;
    dir = (d == 1) ? 0 : (d == 7) ? 1 : (d == 0) ? 2 : 3;
    mdl[i].wrap = ((dir == 0 && q == 0) || (dir == 1 && q == 7)) ? 1 : 0;
    if (dir == 3) begin
      mdl[i].serr = 1;
      mdl[i].run = 0;
      mdl[i].lock = -1;
      if (mdl[i].errc < errMaxOf(i)) mdl[i].errc++;
    end else if (dir < 2) begin
      if (mdl[i].lock >= 0) begin
        if (dir != mdl[i].lock) begin
          mdl[i].lock = dir;
          mdl[i].mout = dir;
          mdl[i].rev = 1;
        end
      end else begin
        if (mdl[i].run > 0 && dir == mdl[i].cand) mdl[i].run++;
        else begin
          mdl[i].run = 1;
          mdl[i].cand = dir;
        end
        if (mdl[i].run == lockNOf(i)) begin
          mdl[i].lock = dir;
          mdl[i].mout = dir;
          mdl[i].run = 0;
        end
      end
    end
    mdl[i].prev = q;
  endtask

  task automatic checkOne(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkOne({tag, " a.m_out"},    int'(m_out_a),    mdl[0].mout);
    checkOne({tag, " a.locked"},   int'(locked_a),   (mdl[0].lock >= 0) ? 1 : 0);
    checkOne({tag, " a.wrap"},     int'(wrap_a),     mdl[0].wrap);
    checkOne({tag, " a.rev"},      int'(rev_a),      mdl[0].rev);
    checkOne({tag, " a.step_err"}, int'(step_err_a), mdl[0].serr);
    checkOne({tag, " a.err_cnt"},  int'(err_cnt_a),  mdl[0].errc);
    checkOne({tag, " b.m_out"},    int'(m_out_b),    mdl[1].mout);
    checkOne({tag, " b.locked"},   int'(locked_b),   (mdl[1].lock >= 0) ? 1 : 0);
    checkOne({tag, " b.wrap"},     int'(wrap_b),     mdl[1].wrap);
    checkOne({tag, " b.rev"},      int'(rev_b),      mdl[1].rev);
    checkOne({tag, " b.step_err"}, int'(step_err_b), mdl[1].serr);
    checkOne({tag, " b.err_cnt"},  int'(err_cnt_b),  mdl[1].errc);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit
  // after the rising edge that captured them.
  task automatic applyStimulus(input bit en, input logic [2:0] q);
    @(negedge clk);
    sample_en = en;
    q_in = q;
    @(posedge clk);
    modelStep(0, en, int'(q));
    modelStep(1, en, int'(q));
    #1;
  endtask

  task automatic doReset();
    @(negedge clk);
    sample_en = 1'b0;
    clr = 1'b0;
    modelReset();
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;
  endtask

  typedef struct {
    bit         en;
    logic [2:0] q;
    bit         locked;
    bit         mout;
    bit         wrap;
    bit         rev;
    bit         serr;
    int         errc;
  } vec_t;

  vec_t vecs[$];

  initial begin
    logic [2:0] qv;
    logic [2:0] lastq;
    bit         en;
    int         r;
    vec_t       v;

    clr = 1'b1;
    sample_en = 1'b0;
    q_in = 3'd0;
    #2;
    clr = 1'b0;
    modelReset();
    #1;
    checkOutput("reset");
    @(negedge clk);
    @(negedge clk);
    clr = 1'b1;

    // Expected outputs of the LOCK_N=2 instance after each sample.
    //                en  q  lck mo wr rv se err
    vecs.push_back('{1, 3'd0, 0, 0, 0, 0, 0, 0}); // seed prev
    vecs.push_back('{1, 3'd1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd2, 1, 0, 0, 0, 0, 0}); // second up step locks
    vecs.push_back('{1, 3'd3, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd4, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd5, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd6, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd7, 1, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd0, 1, 0, 1, 0, 0, 0}); // 7->0 wrap
    vecs.push_back('{1, 3'd7, 1, 1, 1, 1, 0, 0}); // reversal that wraps
    vecs.push_back('{1, 3'd6, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd5, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd4, 1, 1, 0, 0, 0, 0});
    vecs.push_back('{1, 3'd1, 0, 1, 0, 0, 1, 1}); // glitch drops lock
    vecs.push_back('{1, 3'd0, 0, 1, 0, 0, 0, 1}); // run=1 down
    vecs.push_back('{1, 3'd7, 1, 1, 1, 0, 0, 1}); // relock down with wrap
    vecs.push_back('{1, 3'd0, 1, 0, 1, 1, 0, 1}); // reversal to up, wraps
    vecs.push_back('{1, 3'd1, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 3'd2, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 3'd3, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 3'd3, 1, 0, 0, 0, 0, 1}); // holds
    vecs.push_back('{1, 3'd3, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 3'd0, 1, 0, 0, 0, 0, 1}); // gated, random q
    vecs.push_back('{0, 3'd0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 3'd0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 3'd0, 1, 0, 0, 0, 0, 1});
    vecs.push_back('{1, 3'd4, 1, 0, 0, 0, 0, 1}); // prev was held at 3

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      qv = v.en ? v.q : 3'($urandom_range(0, 7));
      applyStimulus(v.en, qv);
      checkOutput($sformatf("vec%0d", i));
      checkOne($sformatf("vec%0d tbl.locked", i),   int'(locked_a),   int'(v.locked));
      checkOne($sformatf("vec%0d tbl.m_out", i),    int'(m_out_a),    int'(v.mout));
      checkOne($sformatf("vec%0d tbl.wrap", i),     int'(wrap_a),     int'(v.wrap));
      checkOne($sformatf("vec%0d tbl.rev", i),      int'(rev_a),      int'(v.rev));
      checkOne($sformatf("vec%0d tbl.step_err", i), int'(step_err_a), int'(v.serr));
      checkOne($sformatf("vec%0d tbl.err_cnt", i),  int'(err_cnt_a),  v.errc);
    end

    // Asynchronous reset while locked, asserted and released between edges.
    #2;
    clr = 1'b0;
    modelReset();
    #1;
    checkOne("async a.locked",   int'(locked_a),   0);
    checkOne("async a.m_out",    int'(m_out_a),    0);
    checkOne("async a.err_cnt",  int'(err_cnt_a),  0);
    checkOne("async a.wrap",     int'(wrap_a),     0);
    checkOne("async a.rev",      int'(rev_a),      0);
    checkOne("async a.step_err", int'(step_err_a), 0);
    checkOne("async b.locked",   int'(locked_b),   0);
    checkOne("async b.err_cnt",  int'(err_cnt_b),  0);
    #3;
    clr = 1'b1;
    applyStimulus(1'b1, 3'd4);
    checkOutput("post_rst4");
    checkOne("post_rst4 a.locked", int'(locked_a), 0);
    applyStimulus(1'b1, 3'd5);
    checkOutput("post_rst5");
    checkOne("post_rst5 a.locked", int'(locked_a), 0);
    applyStimulus(1'b1, 3'd6);
    checkOutput("post_rst6");
    checkOne("post_rst6 a.locked", int'(locked_a), 1);
    checkOne("post_rst6 a.m_out",  int'(m_out_a),  0);

    // Five illegal steps of +3 saturate the 2-bit counter at 3.
    doReset();
    applyStimulus(1'b1, 3'd0);
    checkOutput("sat_seed");
    qv = 3'd0;
    for (int k = 1; k <= 5; k++) begin
      qv = qv + 3'd3;
      applyStimulus(1'b1, qv);
      checkOutput($sformatf("sat%0d", k));
      checkOne($sformatf("sat%0d b.err_cnt", k),  int'(err_cnt_b),  (k < 3) ? k : 3);
      checkOne($sformatf("sat%0d b.step_err", k), int'(step_err_b), 1);
      checkOne($sformatf("sat%0d a.err_cnt", k),  int'(err_cnt_a),  k);
    end

    // Random walk biased towards legal steps so locks actually form.
    doReset();
    lastq = 3'd0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
        checkOutput($sformatf("rnd%0d rst", n));
      end
      en = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      if (r < 4)       qv = lastq + 3'd1;
      else if (r < 7)  qv = lastq - 3'd1;
      else if (r == 7) qv = lastq;
      else             qv = 3'($urandom_range(0, 7));
      if (en) lastq = qv;
      applyStimulus(en, qv);
      checkOutput($sformatf("rnd%0d", n));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
